// File: rtl/bus_decoder.sv
// -----------------------------------------------------------------------------
// bus_decoder
//
// Decodes a 5-bit source index into a registered one-hot bus-drive enable.
// A legal index drives its line for DRIVE_CYCLES cycles and is then followed by
// one turnaround cycle that reports completion. The "no source" index (31)
// skips the drive phase and completes at once. Indices in the gap
// NUM_SOURCES..30 are rejected with a one-cycle error pulse.
//
// Parameters
//   DRIVE_CYCLES  cycles the selected line is held (1..255)
//   NUM_SOURCES   number of valid sources, indices 0..NUM_SOURCES-1
//
// Ports
//   clock    in   1   single clock, rising edge
//   clear    in   1   synchronous active-high reset
//   req      in   1   request strobe, taken only while ready=1
//   sel      in   5   source index to decode, 31 = no source
//   ready    out  1   high while a new request can be accepted
//   out      out  32  registered one-hot drive enable, bit i drives source i
//   done     out  1   one-cycle pulse when an accepted request completes
//   err      out  1   one-cycle pulse when an illegal index is rejected
//   cur_sel  out  5   index of the most recently accepted request
// -----------------------------------------------------------------------------
module bus_decoder #(
    parameter int DRIVE_CYCLES = 1,
    parameter int NUM_SOURCES  = 24
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req,
    input  logic [4:0]  sel,
    output logic        ready,
    output logic [31:0] out,
    output logic        done,
    output logic        err,
    output logic [4:0]  cur_sel
);

    localparam logic [4:0] NO_SOURCE = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        TURN,
        ERR
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [4:0]  cur_sel_nxt;
    logic [31:0] out_nxt;
    logic        done_nxt, err_nxt;

    // Next-state logic. Outputs are derived from the next state so that out,
    // done and err are registered and line up exactly with the state they
    // describe.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_nxt   = state;
        cnt_nxt     = cnt;
        cur_sel_nxt = cur_sel;

        case (state)
            IDLE: begin
                if (req) begin
                    cur_sel_nxt = sel;
                    cnt_nxt     = 8'(DRIVE_CYCLES);
                    if (sel == NO_SOURCE)
                        state_nxt = TURN;
                    else if (int'(sel) < NUM_SOURCES)
                        state_nxt = DRIVE;
                    else
                        state_nxt = ERR;
                end
            end
            DRIVE: begin
                // cnt holds the number of drive cycles still to come,
                // including the current one.
                if (cnt <= 8'd1) begin
                    state_nxt = TURN;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            TURN:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        out_nxt  = (state_nxt == DRIVE) ? (32'h1 << cur_sel_nxt) : 32'h0;
        done_nxt = (state_nxt == TURN);
        err_nxt  = (state_nxt == ERR);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            cur_sel <= NO_SOURCE;
            out     <= 32'h0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cur_sel <= cur_sel_nxt;
            out     <= out_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
        end
    end

    assign ready = (state == IDLE);

endmodule

// File: tb/tb_bus_decoder.sv
// -----------------------------------------------------------------------------
// tb_bus_decoder
//
// Directed bench for bus_decoder. Two instances share clock and clear:
// d1 uses DRIVE_CYCLES=1, d3 uses DRIVE_CYCLES=3, both with 24 sources.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_bus_decoder;

    logic        clock;
    logic        clear;

    logic        req1, req3;
    logic [4:0]  sel1, sel3;
    logic        ready1, ready3;
    logic [31:0] out1, out3;
    logic        done1, done3, err1, err3;
    logic [4:0]  cur_sel1, cur_sel3;

    int n_checks = 0;
    int n_errors = 0;

    bus_decoder #(.DRIVE_CYCLES(1), .NUM_SOURCES(24)) d1 (
        .clock   (clock),
        .clear   (clear),
        .req     (req1),
        .sel     (sel1),
        .ready   (ready1),
        .out     (out1),
        .done    (done1),
        .err     (err1),
        .cur_sel (cur_sel1)
    );

    bus_decoder #(.DRIVE_CYCLES(3), .NUM_SOURCES(24)) d3 (
        .clock   (clock),
        .clear   (clear),
        .req     (req3),
        .sel     (sel3),
        .ready   (ready3),
        .out     (out3),
        .done    (done3),
        .err     (err3),
        .cur_sel (cur_sel3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference one-hot encoder: index of the set bit, 31 if none.
    function automatic logic [4:0] encode(input logic [31:0] v);
        logic [4:0] e;
        e = 5'd31;
        for (int i = 0; i < 32; i++)
            if (v[i]) e = 5'(i);
        return e;
    endfunction

    initial begin
        bit         saw_done, saw_err, saw_out, finished;
        logic [4:0] enc;

        clear = 1'b1;
        req1  = 1'b0; sel1 = 5'd0;
        req3  = 1'b0; sel3 = 5'd0;

        // Reset state
        tick();
        check("rst_ready1",   32'(ready1),   32'd1);
        check("rst_out1",     out1,          32'h0);
        check("rst_done1",    32'(done1),    32'd0);
        check("rst_err1",     32'(err1),     32'd0);
        check("rst_cur_sel1", 32'(cur_sel1), 32'd31);
        check("rst_ready3",   32'(ready3),   32'd1);
        check("rst_cur_sel3", 32'(cur_sel3), 32'd31);

        // DRIVE_CYCLES=1, sel=5, accepted on the first edge after clear drops
        clear = 1'b0;
        req1 = 1'b1; sel1 = 5'd5;
        tick();
        req1 = 1'b0;
        check("s5_out",      out1,           32'h0000_0020);
        check("s5_ready",    32'(ready1),    32'd0);
        check("s5_done_lo",  32'(done1),     32'd0);
        tick();
        check("s5_turn_out", out1,           32'h0);
        check("s5_done",     32'(done1),     32'd1);
        check("s5_err",      32'(err1),      32'd0);
        tick();
        check("s5_ready_back", 32'(ready1),  32'd1);
        check("s5_cur_sel",    32'(cur_sel1), 32'd5);
        check("s5_done_gone",  32'(done1),   32'd0);

        // DRIVE_CYCLES=3, sel=23, sel/req disturbed mid-drive
        req3 = 1'b1; sel3 = 5'd23;
        tick();
        check("s23_c1", out3, 32'h0080_0000);
        sel3 = 5'd2;
        tick();
        check("s23_c2",         out3,          32'h0080_0000);
        check("s23_cur_sel_c2", 32'(cur_sel3), 32'd23);
        tick();
        check("s23_c3",         out3,          32'h0080_0000);
        check("s23_done_c3",    32'(done3),    32'd0);
        req3 = 1'b0;
        tick();
        check("s23_turn_out",   out3,          32'h0);
        check("s23_done",       32'(done3),    32'd1);
        check("s23_cur_sel",    32'(cur_sel3), 32'd23);
        tick();
        check("s23_ready_back", 32'(ready3),   32'd1);
        check("s23_done_gone",  32'(done3),    32'd0);

        // Illegal index 26 -> err only
        req1 = 1'b1; sel1 = 5'd26;
        tick();
        req1 = 1'b0;
        check("s26_err",   32'(err1),  32'd1);
        check("s26_done",  32'(done1), 32'd0);
        check("s26_out",   out1,       32'h0);
        tick();
        check("s26_err_gone", 32'(err1),   32'd0);
        check("s26_ready",    32'(ready1), 32'd1);

        // No source (31) -> done the cycle after acceptance
        req1 = 1'b1; sel1 = 5'd31;
        tick();
        req1 = 1'b0;
        check("s31_done",    32'(done1),    32'd1);
        check("s31_err",     32'(err1),     32'd0);
        check("s31_out",     out1,          32'h0);
        check("s31_cur_sel", 32'(cur_sel1), 32'd31);
        tick();
        check("s31_ready",   32'(ready1),   32'd1);

        // clear in the second drive cycle (DRIVE_CYCLES=3, sel=10)
        req3 = 1'b1; sel3 = 5'd10;
        tick();
        req3 = 1'b0;
        check("clr_c1", out3, 32'h0000_0400);
        tick();
        check("clr_c2", out3, 32'h0000_0400);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_out",     out3,          32'h0);
        check("clr_ready",   32'(ready3),   32'd1);
        check("clr_cur_sel", 32'(cur_sel3), 32'd31);
        check("clr_done",    32'(done3),    32'd0);
        check("clr_err",     32'(err3),     32'd0);
        tick();
        check("clr_done_after", 32'(done3), 32'd0);
        check("clr_out_after",  out3,       32'h0);

        // Back-to-back sweep of every index with req held high
        req1 = 1'b1;
        for (int s = 0; s < 32; s++) begin
            sel1 = 5'(s);
            tick();
            saw_done = 1'b0; saw_err = 1'b0; saw_out = 1'b0;
            enc      = 5'd31;
            finished = 1'b0;
            for (int c = 0; c < 10 && !finished; c++) begin
                check("sweep_onehot", 32'($countones(out1) <= 1), 32'd1);
                check("sweep_excl",   32'(done1 & err1),          32'd0);
                if (done1) saw_done = 1'b1;
                if (err1)  saw_err  = 1'b1;
                if (out1 != 32'h0) begin
                    saw_out = 1'b1;
                    enc     = encode(out1);
                end
                if (ready1) finished = 1'b1;
                else        tick();
            end
            check("sweep_timeout", 32'(finished), 32'd1);
            if (s < 24) begin
                check($sformatf("sweep_rt_%0d", s),   32'(enc),      32'(s));
                check($sformatf("sweep_done_%0d", s), 32'(saw_done), 32'd1);
                check($sformatf("sweep_err_%0d", s),  32'(saw_err),  32'd0);
            end else if (s < 31) begin
                check($sformatf("sweep_err_%0d", s),  32'(saw_err),  32'd1);
                check($sformatf("sweep_done_%0d", s), 32'(saw_done), 32'd0);
                check($sformatf("sweep_out_%0d", s),  32'(saw_out),  32'd0);
            end else begin
                check("sweep_done_31", 32'(saw_done), 32'd1);
                check("sweep_err_31",  32'(saw_err),  32'd0);
                check("sweep_out_31",  32'(saw_out),  32'd0);
            end
        end
        req1 = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 Parameter DRIVE_CYCLES, default 1, cycles the selected one-hot line is held (legal 1..255).
REQ-002 Parameter NUM_SOURCES, default 24, count of valid bus sources (indices 0..NUM_SOURCES-1).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 clear  input  1  synchronous, active-high reset.
REQ-005 req  input  1  request strobe; accepted only when ready=1.
REQ-006 sel  input  5  source index to decode; 5'd31 = "no source".
REQ-007 ready  output  1  high when a new request can be accepted.
REQ-008 out  output  32  registered one-hot bus-drive enable; bit i drives source i.
REQ-009 done  output  1  one-cycle pulse marking completion of an accepted request.
REQ-010 err  output  1  one-cycle pulse marking rejection of an illegal index.
REQ-011 cur_sel  output  5  index of the most recently accepted request.

Function
REQ-012 States SHALL be IDLE, DRIVE, TURN, ERR; ready=1 only in IDLE.
REQ-013 Acceptance: edge with state=IDLE and req=1 latches sel into cur_sel and loads the drive counter with DRIVE_CYCLES.
REQ-014 Legal index (sel < NUM_SOURCES): IDLE->DRIVE; out SHALL equal 32'h1 << cur_sel for exactly DRIVE_CYCLES consecutive cycles, beginning the cycle after acceptance.
REQ-015 DRIVE->TURN when the counter reaches its last cycle; in TURN out=0 for one cycle (bus turnaround), done=1, err=0.
REQ-016 TURN->IDLE unconditionally; req sampled in TURN is ignored.
REQ-017 sel=31: IDLE->TURN directly; out stays 0, done pulses the cycle after acceptance, err=0.
REQ-018 Illegal index (NUM_SOURCES <= sel <= 30): IDLE->ERR; out stays 0; err=1 for one cycle; done=0; ERR->IDLE.
REQ-019 out SHALL never have more than one bit set, and never be nonzero outside DRIVE.
REQ-020 sel and req changes while not in IDLE SHALL have no effect on out, cur_sel, done or err.
REQ-021 done and err SHALL never be high in the same cycle.
REQ-022 Minimum request-to-request spacing: DRIVE_CYCLES+2 cycles for legal, 2 cycles for sel=31 or illegal indices.
REQ-023 Round-trip property: for any legal sel, the active out value, fed to the team's one-hot bus encoder, yields sel.

Reset
REQ-024 clear=1 at a rising edge SHALL force state=IDLE, out=32'h0, ready=1, done=0, err=0, cur_sel=5'd31, counter=0, overriding req.
REQ-025 clear in any state (including mid-DRIVE) SHALL drop out to 0 on that edge with no done or err pulse.
REQ-026 First request can be accepted on the first edge after clear deasserts.

Verification
REQ-027 DRIVE_CYCLES=1, req with sel=5 -> next cycle out=32'h00000020; following cycle out=0, done=1; next cycle ready=1, cur_sel=5.
REQ-028 DRIVE_CYCLES=3, sel=23 -> out=32'h00800000 for exactly 3 cycles, then one cycle out=0 with done=1; sel changed to 2 mid-drive leaves out unchanged.
REQ-029 sel=26 -> err=1 for one cycle, out=0 throughout, done=0; sel=31 -> done=1 the cycle after acceptance, out=0, err=0.
REQ-030 clear asserted in second DRIVE cycle (DRIVE_CYCLES=3, sel=10) -> out=0 and ready=1 on that edge, cur_sel=31, no done.
REQ-031 Sweep sel 0..31 back-to-back, req held high -> each legal index round-trips through the encoder, indices 24..30 produce err only, out popcount <= 1 every cycle.
